// File: rtl/multi_drop_pkg.sv
// Shared definitions for the multi-drop bus master: destination codes, FSM states, defaults.
package multi_drop_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    localparam logic [1:0] DEST_A       = 2'd0;
    localparam logic [1:0] DEST_B       = 2'd1;
    localparam logic [1:0] DEST_C       = 2'd2;
    localparam logic [1:0] DEST_ILLEGAL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_e;

    // Enable vector ordered {enc, enb, ena}; illegal codes give no enable.
    function automatic logic [2:0] dest_onehot(input logic [1:0] dest);
        logic [2:0] oh;
        oh = 3'b000;
        case (dest)
            DEST_A:  oh = 3'b001;
            DEST_B:  oh = 3'b010;
            DEST_C:  oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/multi_drop_fifo.sv
// Synchronous request FIFO with wrap-around pointers and an occupancy count.
module multi_drop_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];

    // A full FIFO never accepts, even when a pop frees a slot on the same edge.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) wptr_d = wptr_q + PTR_W'(1);
        if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/multi_drop_driver.sv
// Multi-drop bus master: queues (dest, data) requests and drives each word with
// a single one-hot drop enable for one cycle, followed by an idle gap.
module multi_drop_driver
    import multi_drop_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_dest,
    input  logic [DATA_W-1:0] in_data,
    output logic [DATA_W-1:0] bus,
    output logic              ena,
    output logic              enb,
    output logic              enc,
    output logic              busy,
    output logic              err
);

    localparam int unsigned ENTRY_W = DATA_W + 2;
    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [3:0]  GAP_LOAD = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

    state_e              state_q, state_d;
    logic [3:0]          gap_q, gap_d;
    logic [DATA_W-1:0]   bus_q, bus_d;
    logic [2:0]          en_q, en_d;
    logic                err_q, err_d;

    logic                accept, illegal, push, pop, launch;
    logic                full, empty;
    logic [CNT_W-1:0]    count;
    logic [ENTRY_W-1:0]  head;
    logic [1:0]          head_dest;
    logic [DATA_W-1:0]   head_data;

    assign in_ready  = !full;
    assign accept    = in_valid && in_ready;
    assign illegal   = (in_dest == DEST_ILLEGAL);
    assign push      = accept && !illegal;
    assign err_d     = accept && illegal;
    assign head_dest = head[ENTRY_W-1 -: 2];
    assign head_data = head[DATA_W-1:0];

    multi_drop_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_dest, in_data}),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    // Next-state: IDLE, a zero-gap DRIVE and an expired GAP all share the launch path.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        bus_d   = bus_q;
        en_d    = 3'b000;
        pop     = 1'b0;
        launch  = 1'b0;
        case (state_q)
            IDLE: launch = 1'b1;
            DRIVE: begin
                if (GAP_CYCLES == 0) begin
                    launch = 1'b1;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) launch = 1'b1;
                else               gap_d  = gap_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        if (launch) begin
            if (!empty) begin
                pop     = 1'b1;
                bus_d   = head_data;
                en_d    = dest_onehot(head_dest);
                state_d = DRIVE;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gap_q   <= 4'd0;
            bus_q   <= '0;
            en_q    <= 3'b000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            bus_q   <= bus_d;
            en_q    <= en_d;
            err_q   <= err_d;
        end
    end

    assign bus  = bus_q;
    assign ena  = en_q[0];
    assign enb  = en_q[1];
    assign enc  = en_q[2];
    assign err  = err_q;
    assign busy = (count != '0) || (state_q != IDLE);

endmodule
